// File: rtl/cfg_bitstream_loader.sv
// rtl/cfg_bitstream_loader.sv - serial config loader: sync hunt, payload capture, even-parity commit
module cfg_bitstream_loader #(
    parameter logic [7:0] SYNC_WORD = 8'hA5,
    parameter int         CFG_WIDTH = 8,
    parameter int         TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    output logic                 bit_ready,
    output logic [CFG_WIDTH-1:0] bitfile,
    output logic                 cfg_done,
    output logic                 cfg_error,
    output logic                 busy,
    output logic [7:0]           load_count
);

    localparam int HW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(CFG_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, HUNT, LOAD, PARITY, ERROR} state_t;

    state_t               state, state_n;
    logic [7:0]           window, window_n, window_shift;
    logic [HW-1:0]        hunt_cnt, hunt_cnt_n;
    logic [BW-1:0]        bit_cnt, bit_cnt_n;
    logic [CFG_WIDTH-1:0] shadow, shadow_n;
    logic [CFG_WIDTH-1:0] bitfile_n;
    logic [7:0]           load_count_n;
    logic                 cfg_done_n;
    logic                 accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            window     <= '0;
            hunt_cnt   <= '0;
            bit_cnt    <= '0;
            shadow     <= '0;
            bitfile    <= '0;
            cfg_done   <= 1'b0;
            load_count <= '0;
        end else begin
            state      <= state_n;
            window     <= window_n;
            hunt_cnt   <= hunt_cnt_n;
            bit_cnt    <= bit_cnt_n;
            shadow     <= shadow_n;
            bitfile    <= bitfile_n;
            cfg_done   <= cfg_done_n;
            load_count <= load_count_n;
        end
    end

    always_comb begin
        state_n      = state;
        window_n     = window;
        hunt_cnt_n   = hunt_cnt;
        bit_cnt_n    = bit_cnt;
        shadow_n     = shadow;
        bitfile_n    = bitfile;
        cfg_done_n   = 1'b0;
        load_count_n = load_count;
        bit_ready    = 1'b0;
        busy         = 1'b0;
        cfg_error    = 1'b0;

        case (state)
            IDLE:   bit_ready = 1'b1;
            HUNT,
            LOAD,
            PARITY: begin
                bit_ready = 1'b1;
                busy      = 1'b1;
            end
            ERROR: begin
                bit_ready = 1'b1;
                cfg_error = 1'b1;
            end
            default: ;
        endcase

        accept       = bit_valid && bit_ready;
        window_shift = {window[6:0], bit_in};

        // start beats any bit presented in the same cycle and restarts from a clean hunt
        if (start) begin
            state_n    = HUNT;
            window_n   = '0;
            hunt_cnt_n = '0;
            bit_cnt_n  = '0;
            shadow_n   = '0;
        end else if (accept) begin
            case (state)
                HUNT: begin
                    window_n   = window_shift;
                    hunt_cnt_n = hunt_cnt + 1'b1;
                    if (window_shift == SYNC_WORD) begin
                        state_n   = LOAD;
                        bit_cnt_n = '0;
                    end else if (hunt_cnt == HW'(TIMEOUT - 1)) begin
                        state_n = ERROR;
                    end
                end
                LOAD: begin
                    shadow_n  = {shadow[CFG_WIDTH-2:0], bit_in};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == BW'(CFG_WIDTH - 1)) begin
                        state_n = PARITY;
                    end
                end
                PARITY: begin
                    if ((^shadow ^ bit_in) == 1'b0) begin
                        bitfile_n    = shadow;
                        cfg_done_n   = 1'b1;
                        load_count_n = load_count + 8'd1;
                        state_n      = IDLE;
                    end else begin
                        state_n = ERROR;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// tb/tb_cfg_bitstream_loader.sv - directed-vector bench for cfg_bitstream_loader
module tb_cfg_bitstream_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       bit_valid;
    logic       bit_in;
    logic       bit_ready;
    logic [7:0] bitfile;
    logic       cfg_done;
    logic       cfg_error;
    logic       busy;
    logic [7:0] load_count;

    int vectors = 0;
    int miscompares = 0;

    cfg_bitstream_loader #(
        .SYNC_WORD (8'hA5),
        .CFG_WIDTH (8),
        .TIMEOUT   (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .bit_ready  (bit_ready),
        .bitfile    (bitfile),
        .cfg_done   (cfg_done),
        .cfg_error  (cfg_error),
        .busy       (busy),
        .load_count (load_count)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic gap();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic good_load(input logic [7:0] payload);
        pulse_start();
        send_byte(8'hA5);
        send_byte(payload);
        send_bit(^payload);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        gap();
        gap();
        expect_eq("rst_bitfile", bitfile, 8'h00);
        expect_eq("rst_done", cfg_done, 1'b0);
        expect_eq("rst_error", cfg_error, 1'b0);
        expect_eq("rst_busy", busy, 1'b0);
        expect_eq("rst_count", load_count, 8'd0);
        expect_eq("rst_ready", bit_ready, 1'b1);
        reset = 1'b1;
        gap();

        // T1: clean load of 3C
        pulse_start();
        expect_eq("t1_busy_hunt", busy, 1'b1);
        send_byte(8'hA5);
        send_byte(8'h3C);
        expect_eq("t1_pre_bitfile", bitfile, 8'h00);
        send_bit(1'b0);
        expect_eq("t1_bitfile", bitfile, 8'h3C);
        expect_eq("t1_done", cfg_done, 1'b1);
        expect_eq("t1_count", load_count, 8'd1);
        expect_eq("t1_busy", busy, 1'b0);
        gap();
        expect_eq("t1_done_pulse", cfg_done, 1'b0);

        // T2: parity error keeps last good config
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_bit(1'b1);
        expect_eq("t2_error", cfg_error, 1'b1);
        expect_eq("t2_done", cfg_done, 1'b0);
        expect_eq("t2_bitfile", bitfile, 8'h3C);
        expect_eq("t2_count", load_count, 8'd1);
        gap();
        expect_eq("t2_error_held", cfg_error, 1'b1);
        pulse_start();
        expect_eq("t2_error_clr", cfg_error, 1'b0);
        expect_eq("t2_busy", busy, 1'b1);

        // T3: timeout in HUNT, gaps make no progress
        for (int i = 0; i < 15; i++) begin
            send_bit(1'b0);
            gap();
            gap();
        end
        expect_eq("t3_15_error", cfg_error, 1'b0);
        expect_eq("t3_15_busy", busy, 1'b1);
        send_bit(1'b0);
        expect_eq("t3_16_error", cfg_error, 1'b1);
        expect_eq("t3_16_busy", busy, 1'b0);

        // T4: restart mid-LOAD with a simultaneous bit, then a clean frame
        pulse_start();
        send_byte(8'hA5);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        start     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        gap();
        start     = 1'b0;
        bit_valid = 1'b0;
        expect_eq("t4_abort_bitfile", bitfile, 8'h3C);
        expect_eq("t4_abort_busy", busy, 1'b1);
        send_byte(8'hA5);
        send_byte(8'h81);
        expect_eq("t4_pre_done", cfg_done, 1'b0);
        send_bit(1'b0);
        expect_eq("t4_bitfile", bitfile, 8'h81);
        expect_eq("t4_done", cfg_done, 1'b1);
        expect_eq("t4_count", load_count, 8'd2);

        // T5: asynchronous reset mid-LOAD
        pulse_start();
        send_byte(8'hA5);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        #1;
        reset = 1'b0;
        #1;
        expect_eq("t5_bitfile", bitfile, 8'h00);
        expect_eq("t5_count", load_count, 8'd0);
        expect_eq("t5_busy", busy, 1'b0);
        expect_eq("t5_error", cfg_error, 1'b0);
        expect_eq("t5_done", cfg_done, 1'b0);
        #1;
        reset = 1'b1;
        gap();
        send_byte(8'hA5);
        send_byte(8'hFF);
        send_bit(1'b0);
        expect_eq("t5_idle_discard_busy", busy, 1'b0);
        expect_eq("t5_idle_discard_bitfile", bitfile, 8'h00);

        // T6: load_count wrap, plus a junk bit ahead of the sync word
        for (int i = 0; i < 255; i++) good_load(8'(i));
        expect_eq("t6_count_255", load_count, 8'hFF);
        expect_eq("t6_bitfile_fe", bitfile, 8'hFE);
        pulse_start();
        send_bit(1'b1);
        send_byte(8'hA5);
        send_byte(8'hC3);
        send_bit(1'b0);
        expect_eq("t6_count_wrap", load_count, 8'h00);
        expect_eq("t6_bitfile", bitfile, 8'hC3);
        expect_eq("t6_done", cfg_done, 1'b1);
        expect_eq("t6_error", cfg_error, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
